// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe 640x480@60 with negative syncs.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_CW       = 12;

    localparam bit POL_NEG = 1'b1;
    localparam bit POL_POS = 1'b0;

    function automatic int totalLen(
        input int active,
        input int front,
        input int sync,
        input int back
    );
        return active + front + sync + back;
    endfunction

    // Drive level of a sync pin for a given logical state
    function automatic logic syncLevel(
        input bit   neg,
        input logic act
    );
        return neg ? ~act : act;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping raster-axis counter with boundary compares
// evaluated on the next-state count so decodes align with it.
module vga_axis_counter #(
    parameter int CW    = 12,
    parameter int TOTAL = 800,
    parameter int SEG_A = 640,
    parameter int SEG_B = 656,
    parameter int SEG_C = 752,
    parameter int SEG_D = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc,
    output logic          nextLtA,
    output logic          nextGeB,
    output logic          nextLtC,
    output logic          nextEqD
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] countNext;
    logic [31:0]   nextWide;

    // Next count and segment compares on that next value
    always_comb begin
        tc = (count == LAST);
        if (!en) begin
            countNext = count;
        end else if (tc) begin
            countNext = '0;
        end else begin
            countNext = count + 1'b1;
        end
        nextWide = 32'(countNext);
        nextLtA  = nextWide < 32'(SEG_A);
        nextGeB  = nextWide >= 32'(SEG_B);
        nextLtC  = nextWide < 32'(SEG_C);
        nextEqD  = nextWide == 32'(SEG_D);
    end

    // Reset parks the axis on its last position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else begin
            count <= countNext;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/CEA raster timing generator on a pixel enable.
// Optional test pattern on rgb when VGA_TIMING_PATTERN_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FRONT    = DEF_H_FRONT,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BACK     = DEF_H_BACK,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FRONT    = DEF_V_FRONT,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BACK     = DEF_V_BACK,
    parameter bit H_SYNC_NEG = POL_NEG,
    parameter bit V_SYNC_NEG = POL_NEG,
    parameter int CW         = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [15:0]   frame_cnt,
    output logic [2:0]    rgb
);

    localparam int H_TOTAL =
        totalLen(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL =
        totalLen(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    localparam logic H_ON  = syncLevel(H_SYNC_NEG, 1'b1);
    localparam logic H_OFF = syncLevel(H_SYNC_NEG, 1'b0);
    localparam logic V_ON  = syncLevel(V_SYNC_NEG, 1'b1);
    localparam logic V_OFF = syncLevel(V_SYNC_NEG, 1'b0);

    logic hTc, hLtA, hGeB, hLtC, hZero;
    logic vTc, vLtA, vGeB, vLtC, vAtBlank;
    logic vEn;
    logic deNext;
    logic started;

    assign vEn    = pix_ce & hTc;
    assign deNext = hLtA & vLtA;

    vga_axis_counter #(
        .CW    (CW),
        .TOTAL (H_TOTAL),
        .SEG_A (H_ACTIVE),
        .SEG_B (H_ACTIVE + H_FRONT),
        .SEG_C (H_ACTIVE + H_FRONT + H_SYNC),
        .SEG_D (0)
    ) hAxis (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (pix_ce),
        .count   (h_count),
        .tc      (hTc),
        .nextLtA (hLtA),
        .nextGeB (hGeB),
        .nextLtC (hLtC),
        .nextEqD (hZero)
    );

    vga_axis_counter #(
        .CW    (CW),
        .TOTAL (V_TOTAL),
        .SEG_A (V_ACTIVE),
        .SEG_B (V_ACTIVE + V_FRONT),
        .SEG_C (V_ACTIVE + V_FRONT + V_SYNC),
        .SEG_D (V_ACTIVE)
    ) vAxis (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (vEn),
        .count   (v_count),
        .tc      (vTc),
        .nextLtA (vLtA),
        .nextGeB (vGeB),
        .nextLtC (vLtC),
        .nextEqD (vAtBlank)
    );

    // Decodes registered from next-state counters; strobes fire once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de           <= 1'b0;
            hsync        <= H_OFF;
            vsync        <= V_OFF;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            frame_cnt    <= 16'd0;
            started      <= 1'b0;
        end else if (pix_ce) begin
            de           <= deNext;
            hsync        <= (hGeB & hLtC) ? H_ON : H_OFF;
            vsync        <= (vGeB & vLtC) ? V_ON : V_OFF;
            line_start   <= hZero;
            frame_start  <= hTc & vTc;
            vblank_start <= hZero & vAtBlank;
            started      <= 1'b1;
            // The wrap out of the reset position is not a finished frame
            if (hTc && vTc && started) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end else begin
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_PATTERN_EN
    logic [CW-1:0] hNextPix;
    logic [2:0]    bar;

    assign hNextPix = hTc ? '0 : h_count + 1'b1;
    assign bar = 3'({hNextPix, 3'b000} / (CW+3)'(H_ACTIVE));

    // Eight vertical colour bars, blanked outside the active area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb <= 3'b000;
        end else if (pix_ce) begin
            rgb <= deNext ? bar : 3'b000;
        end
    end
`else
    assign rgb = 3'b000;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised pixel-enable bench for vga_timing_gen against a
// linear pixel-index model of the raster.
module tb_vga_timing_gen;

    localparam int HA = 16;
    localparam int HF = 0;
    localparam int HS = 4;
    localparam int HB = 3;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam bit HSN = 1'b0;
    localparam bit VSN = 1'b1;
    localparam int CW = 8;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic          clk;
    logic          rst_n;
    logic          pix_ce;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
    logic          vblank_start;
    logic [15:0]   frame_cnt;
    logic [2:0]    rgb;

    vga_timing_gen #(
        .H_ACTIVE   (HA),
        .H_FRONT    (HF),
        .H_SYNC     (HS),
        .H_BACK     (HB),
        .V_ACTIVE   (VA),
        .V_FRONT    (VF),
        .V_SYNC     (VS),
        .V_BACK     (VB),
        .H_SYNC_NEG (HSN),
        .V_SYNC_NEG (VSN),
        .CW         (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pix_ce       (pix_ce),
        .h_count      (h_count),
        .v_count      (v_count),
        .de           (de),
        .hsync        (hsync),
        .vsync        (vsync),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .frame_cnt    (frame_cnt),
        .rgb          (rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     nChecks = 0;
    int     nFails  = 0;
    longint nPix    = 0;
    int     clkIdx  = 0;
    int     lastLine = -1;
    bit     periodMode = 1'b0;

    task automatic checkVal(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Expected outputs follow from how many enables were seen
    task automatic checkAll(input bit ce);
        int p, h, v, fc;
        bit hAct, vAct, xDe, ls, fs, vb;
        int xRgb;
        if (nPix == 0) begin
            p  = FT - 1;
            fc = 0;
        end else begin
            p  = int'((nPix - 1) % FT);
            fc = int'(((nPix - 1) / FT) % 65536);
        end
        h    = p % HT;
        v    = p / HT;
        hAct = (h >= HA + HF) && (h < HA + HF + HS);
        vAct = (v >= VA + VF) && (v < VA + VF + VS);
        xDe  = (h < HA) && (v < VA);
        ls   = ce && (nPix > 0) && (h == 0);
        fs   = ce && (nPix > 0) && (p == 0);
        vb   = ce && (nPix > 0) && (h == 0) && (v == VA);
`ifdef VGA_TIMING_PATTERN_EN
        xRgb = xDe ? (h * 8) / HA : 0;
`else
        xRgb = 0;
`endif
        checkVal("h_count", 32'(h_count), h);
        checkVal("v_count", 32'(v_count), v);
        checkVal("de", 32'(de), 32'(xDe));
        checkVal("hsync", 32'(hsync), 32'(HSN ? !hAct : hAct));
        checkVal("vsync", 32'(vsync), 32'(VSN ? !vAct : vAct));
        checkVal("line_start", 32'(line_start), 32'(ls));
        checkVal("frame_start", 32'(frame_start), 32'(fs));
        checkVal("vblank_start", 32'(vblank_start), 32'(vb));
        checkVal("frame_cnt", 32'(frame_cnt), fc);
        checkVal("rgb", 32'(rgb), xRgb);
    endtask

    task automatic step(input bit ce);
        @(negedge clk);
        pix_ce = ce;
        @(posedge clk);
        #1;
        clkIdx++;
        if (ce) nPix++;
        checkAll(ce);
        if (periodMode && line_start) begin
            if (lastLine >= 0) begin
                checkVal("line_period", clkIdx - lastLine, 3 * HT);
            end
            lastLine = clkIdx;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int guard;
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAll(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous enable over two full frames
        repeat (2 * FT + 10) step(1'b1);

        // One enable in three clocks
        periodMode = 1'b1;
        lastLine   = -1;
        for (int i = 0; i < 3 * HT * 4; i++) begin
            step(i % 3 == 0);
        end
        periodMode = 1'b0;

        // Randomly gated enable
        repeat (1500) step(($urandom % 4) != 0);

        // Walk to a mid-frame point and reset asynchronously
        target = 7 * HT + HA / 2;
        guard  = 0;
        while (((nPix - 1) % FT) != target && guard < FT + 2) begin
            step(1'b1);
            guard++;
        end
        checkVal("reach_target", 32'(int'((nPix - 1) % FT)), target);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        nPix  = 0;
        #1;
        checkAll(1'b0);
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        checkAll(1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        pix_ce = 1'b0;
        step(1'b1);
        repeat (600) step(($urandom % 3) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule
